imem_fetch_responder: RTL and testbench
=======================================

// Module: imem_fetch_responder
// PURPOSE
//  Instruction-memory side of the PC fetch interface: accepts fetch addresses from the PC stage,
//  reads a synchronous instruction RAM and returns instruction words through a valid/ready response.
//  Sits between the PC register and decode; a loader port fills the RAM before run.
//  A flush input discards in-flight and buffered fetches on branch/jump redirect.
// PARAMETERS
//  ADDR_W  10    fetch/load address width (matches the PC width)
//  DATA_W  16    instruction word width
//  DEPTH   1024  implemented words; addresses >= DEPTH are out of range
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       synchronous, active-high
//  req_valid  in   1       PC stage presents a fetch address
//  req_addr   in   ADDR_W  fetch address (word-addressed)
//  req_ready  out  1       request accepted when req_valid & req_ready at clk edge
//  rsp_valid  out  1       instruction word available
//  rsp_ready  in   1       decode consumes word when rsp_valid & rsp_ready
//  rsp_data   out  DATA_W  instruction word
//  rsp_addr   out  ADDR_W  address the word was fetched from
//  rsp_err    out  1       word invalid (out of range, or parity fault when enabled)
//  flush      in   1       drop all in-flight and buffered responses
//  load_en    in   1       write load_data to RAM[load_addr] this cycle
//  load_addr  in   ADDR_W  loader address
//  load_data  in   DATA_W  loader data
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_err=0, rsp_data=0, rsp_addr=0, buffer empty, no read in flight,
//    req_ready=0 during reset cycle. RAM contents are not cleared.
//  - Latency: request accepted at edge N -> RAM read registered at N+1 -> enters 2-entry response
//    buffer; rsp_valid high from cycle N+1 when buffer was empty (1-cycle fetch latency).
//  - Throughput: one request per cycle while decode drains each cycle; responses in request order.
//  - req_ready = !reset & !load_en & !flush & (buf_count + inflight < 2); never accept a
//    request that could overflow the buffer (no backpressure loss).
//  - rsp_valid/rsp_data/rsp_addr/rsp_err hold stable while rsp_valid & !rsp_ready.
//  - Out-of-range req_addr (>= DEPTH): response issued, rsp_data=0, rsp_err=1.
//  - flush: at the edge, in-flight read and buffer cleared; rsp_valid=0 next cycle; any request
//    in the same cycle is not accepted (req_ready=0). Flush+rsp_ready same cycle: pop ignored.
//  - Simultaneous push and pop with buffer full: allowed, count unchanged.
//  - load_en: write at the edge; reads blocked (req_ready=0); an in-flight read completes normally.
//    Load to out-of-range address ignored. Read-during-write to same address not possible by design.
//  - Control FSM: IDLE (buffer empty, none in flight) -> BUSY (any entry/in-flight) -> IDLE when drained;
//    flush or reset -> IDLE from any state.
// CONFIGURATION
//  IMEM_PARITY_EN defined: RAM stores DATA_W+1 bits; even parity generated on load, checked on read;
//    mismatch -> rsp_err=1, rsp_data returns raw stored word. Extra port-less cost only.
//  IMEM_PARITY_EN undefined: RAM is DATA_W wide; rsp_err asserted only for out-of-range fetches.
// STRUCTURE
//  - imem_pkg: ADDR_W/DATA_W defaults, NOP_WORD constant (16'h0000), typedef imem_rsp_t
//    {data, addr, err}, typedef fsm state enum {IDLE, BUSY}.
//  - Sub-module imem_rsp_fifo: 2-entry FIFO of imem_rsp_t with sync clear (flush/reset).
//  - Top holds RAM array, in-flight register, ready/credit logic and FSM.
// TESTING
//  1 Load RAM[0..3]=16'h1111,2222,3333,4444; fetch 0,1,2,3 back-to-back, rsp_ready=1 ->
//    rsp_data 1111..4444 on consecutive cycles starting 1 cycle after first accept, rsp_err=0.
//  2 rsp_ready=0, issue fetches 0,1,2 -> only 2 accepted (req_ready drops), rsp_data holds 16'h1111;
//    release rsp_ready -> 1111,2222 in order, then fetch 2 accepted.
//  3 Fetch 5,6 then flush in cycle after accept of 6 -> rsp_valid=0 next cycle, no stale word
//    delivered; following fetch 0 returns 16'h1111.
//  4 Fetch addr 10'd1023 with DEPTH=1000 -> rsp_data=0, rsp_err=1, rsp_addr=1023.
//  5 Assert reset with 2 buffered responses -> rsp_valid=0 next cycle; RAM[0] still 16'h1111 after.
//  6 IMEM_PARITY_EN: backdoor-flip one bit of RAM[2] -> fetch 2 gives rsp_err=1; without
//    the macro same fetch gives rsp_err=0 and corrupted data.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg
//   Shared definitions for the instruction-memory fetch responder.
//   - IMEM_ADDR_W / IMEM_DATA_W / IMEM_DEPTH : default geometry (PC width,
//     instruction width, implemented words)
//   - NOP_WORD    : word returned for out-of-range fetches
//   - imem_rsp_t  : one response entry {data, addr, err}
//   - imem_state_e: control FSM states
//   - imem_in_range(): address range check shared by fetch and load paths
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W = 10;
  localparam int unsigned IMEM_DATA_W = 16;
  localparam int unsigned IMEM_DEPTH  = 1024;

  localparam logic [IMEM_DATA_W-1:0] NOP_WORD = 16'h0000;

  typedef struct packed {
    logic [IMEM_DATA_W-1:0] data;
    logic [IMEM_ADDR_W-1:0] addr;
    logic                   err;
  } imem_rsp_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } imem_state_e;

  function automatic logic imem_in_range(input logic [IMEM_ADDR_W-1:0] addr,
                                         input int unsigned depth);
    return (32'(addr) < depth);
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// imem_rsp_fifo
//   Two-entry response FIFO of imem_rsp_t with synchronous clear.
//   A push into a full FIFO is accepted only when a pop happens in the same
//   cycle (count unchanged); otherwise it is dropped, which the upstream
//   credit logic never allows.
// Ports
//   i_clk    clock, rising edge
//   i_clr    synchronous clear (reset or flush): empties the FIFO
//   i_push   write i_wdata
//   i_wdata  entry to write
//   i_pop    discard head entry
//   o_rdata  head entry (meaningless when o_empty)
//   o_empty  FIFO holds no entries
//   o_count  number of entries held (0..2)
module imem_rsp_fifo
  import imem_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_clr,
  input  logic      i_push,
  input  imem_rsp_t i_wdata,
  input  logic      i_pop,
  output imem_rsp_t o_rdata,
  output logic      o_empty,
  output logic [1:0] o_count
);

  imem_rsp_t  r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  // When full, the slot being written is the one being popped this cycle.
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
    end
  end

  // Storage is not reset; contents are only observed through a valid count.
  always_ff @(posedge i_clk) begin
    if (!i_clr && w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder
//   Instruction-memory side of the PC fetch interface. Fetch requests read a
//   synchronous instruction RAM; the registered read word (the "in-flight"
//   entry) is presented directly on the response port when nothing older is
//   buffered, otherwise it is queued in a 2-entry response FIFO. A loader port
//   fills the RAM before run; flush drops everything in flight or buffered.
//
//   Optional feature macro: IMEM_PARITY_EN
//     defined   : RAM is DATA_W+1 wide, even parity written on load and
//                 checked on read; a mismatch sets rsp_err and returns the raw
//                 stored data bits.
//     undefined : RAM is DATA_W wide; rsp_err only flags out-of-range fetches.
//
// Parameters
//   ADDR_W  fetch/load address width (must match imem_pkg::IMEM_ADDR_W)
//   DATA_W  instruction width        (must match imem_pkg::IMEM_DATA_W)
//   DEPTH   implemented words; addresses >= DEPTH are out of range
// Ports
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   fetch handshake, req_addr = word address
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/addr/err     response word, its address, invalid-word flag
//   flush                 discard in-flight and buffered responses
//   load_en/addr/data     RAM write port (blocks fetches while active)
//
// FSM
//   state   | meaning
//   ST_IDLE | buffer empty, no read in flight
//   ST_BUSY | at least one buffered entry or read in flight
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = IMEM_DATA_W,
  parameter int unsigned DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

`ifdef IMEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0] r_mem [DEPTH];

  imem_rsp_t   r_inf;
  logic        r_inf_vld;
  imem_state_e r_state;
  imem_state_e w_state_nxt;

  logic [MEM_W-1:0]  w_wr_word;
  logic [MEM_W-1:0]  w_rd_word;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_perr;
  logic              w_req_in_range;
  logic              w_load_in_range;
  logic              w_accept;
  logic [1:0]        w_occ;
  logic [1:0]        w_fifo_cnt;
  logic [1:0]        w_fifo_cnt_nxt;
  logic              w_fifo_empty;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic              w_fifo_clr;
  logic              w_drained;
  imem_rsp_t         w_fifo_head;
  imem_rsp_t         w_head;

  // ---------------------------------------------------------------- RAM
  assign w_req_in_range  = imem_in_range(req_addr, DEPTH);
  assign w_load_in_range = imem_in_range(load_addr, DEPTH);
  assign w_rd_word       = r_mem[req_addr];

`ifdef IMEM_PARITY_EN
  assign w_wr_word = {^load_data, load_data};
  assign w_rd_data = w_rd_word[DATA_W-1:0];
  assign w_rd_perr = ^w_rd_word;
`else
  assign w_wr_word = load_data;
  assign w_rd_data = w_rd_word;
  assign w_rd_perr = 1'b0;
`endif

  // Fetches are blocked while loading, so a read never hits a word being written.
  always_ff @(posedge clk) begin
    if (load_en && w_load_in_range) r_mem[load_addr] <= w_wr_word;
  end

  // ------------------------------------------------------- credit logic
  // Occupancy counts buffered entries plus the in-flight read; a request is
  // only taken when there is guaranteed room for its response.
  assign w_occ     = w_fifo_cnt + 2'(r_inf_vld);
  assign req_ready = !reset && !load_en && !flush && (w_occ < 2'd2);
  assign w_accept  = req_valid && req_ready;

  // -------------------------------------------------- in-flight register
  // The in-flight entry always leaves after one cycle: either it is consumed
  // straight off the response port or it is pushed into the FIFO.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_inf_vld <= 1'b0;
      r_inf     <= '0;
    end else if (w_accept) begin
      r_inf_vld  <= 1'b1;
      r_inf.addr <= req_addr;
      if (w_req_in_range) begin
        r_inf.data <= w_rd_data;
        r_inf.err  <= w_rd_perr;
      end else begin
        r_inf.data <= NOP_WORD;
        r_inf.err  <= 1'b1;
      end
    end else begin
      r_inf_vld <= 1'b0;
    end
  end

  // ------------------------------------------------------- response FIFO
  assign w_fifo_clr  = reset || flush;
  assign w_fifo_pop  = !w_fifo_empty && rsp_ready && !flush;
  // In-flight word bypasses the FIFO only when it is the visible head and taken.
  assign w_fifo_push = r_inf_vld && !(w_fifo_empty && rsp_ready) && !flush;

  imem_rsp_fifo u_rsp_fifo (
    .i_clk   (clk),
    .i_clr   (w_fifo_clr),
    .i_push  (w_fifo_push),
    .i_wdata (r_inf),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

  assign w_fifo_cnt_nxt = w_fifo_cnt + 2'(w_fifo_push) - 2'(w_fifo_pop);
  assign w_drained      = (w_fifo_cnt_nxt == 2'd0) && !w_accept;

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_drained) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end

  // ------------------------------------------------------ response port
  always_comb begin
    w_head    = w_fifo_empty ? r_inf : w_fifo_head;
    rsp_valid = (r_state == ST_BUSY) && (!w_fifo_empty || r_inf_vld);
    rsp_data  = '0;
    rsp_addr  = '0;
    rsp_err   = 1'b0;
    if (rsp_valid) begin
      rsp_data = w_head.data;
      rsp_addr = w_head.addr;
      rsp_err  = w_head.err;
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1000;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;
  logic              flush;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] exp_w [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  always #5 clk = ~clk;

  imem_fetch_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .flush     (flush),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [DATA_W-1:0] d,
                         input logic [ADDR_W-1:0] a, input logic e);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'(v));
    chk({tag, ".data"},  32'(rsp_data),  32'(d));
    chk({tag, ".addr"},  32'(rsp_addr),  32'(a));
    chk({tag, ".err"},   32'(rsp_err),   32'(e));
  endtask

  initial begin
    logic [DATA_W:0] word;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;

    // reset state
    tick();
    req_valid = 1'b1;
    #1 chk("rst_req_ready", 32'(req_ready), 0);
    tick();
    chk_rsp("rst", 0, 16'h0, 10'd0, 0);
    req_valid = 1'b0;
    reset = 1'b0;
    tick();

    // 1: load, then back-to-back fetches with decode draining
    for (int i = 0; i < 4; i++) load_word(10'(i), exp_w[i]);
    load_word(10'd5, 16'h5555);
    load_word(10'd6, 16'h6666);
    load_word(10'd999, 16'h9999);
    req_valid = 1'b1; req_addr = 10'd0; load_en = 1'b1; load_addr = 10'd7; load_data = 16'h7777;
    #1 chk("load_blocks_req", 32'(req_ready), 0);
    tick();
    load_en = 1'b0;
    chk("load_no_rsp", 32'(rsp_valid), 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 10'(i);
      #1 chk($sformatf("t1_ready%0d", i), 32'(req_ready), 1);
      tick();
      chk_rsp($sformatf("t1_rsp%0d", i), 1, exp_w[i], 10'(i), 0);
    end
    req_valid = 1'b0;
    tick();
    chk("t1_drained", 32'(rsp_valid), 0);

    // 2: decode stalled, only two fetches fit
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 10'd0;
    tick();
    req_addr = 10'd1;
    #1 chk("t2_ready_a1", 32'(req_ready), 1);
    tick();
    req_addr = 10'd2;
    #1 chk("t2_ready_a2", 32'(req_ready), 0);
    tick();
    chk_rsp("t2_hold1", 1, 16'h1111, 10'd0, 0);
    chk("t2_still_full", 32'(req_ready), 0);
    tick();
    chk_rsp("t2_hold2", 1, 16'h1111, 10'd0, 0);
    rsp_ready = 1'b1;
    tick();
    chk_rsp("t2_rsp1", 1, 16'h2222, 10'd1, 0);
    chk("t2_ready_after_pop", 32'(req_ready), 1);
    tick();
    chk_rsp("t2_rsp2", 1, 16'h3333, 10'd2, 0);
    req_valid = 1'b0;
    tick();
    chk("t2_drained", 32'(rsp_valid), 0);

    // 3: flush discards buffered and in-flight words
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 10'd5;
    tick();
    req_addr = 10'd6;
    tick();
    req_addr = 10'd0; flush = 1'b1; rsp_ready = 1'b1;
    #1 chk("t3_flush_blocks_req", 32'(req_ready), 0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    chk_rsp("t3_after_flush", 0, 16'h0, 10'd0, 0);
    tick();
    chk("t3_no_stale", 32'(rsp_valid), 0);
    req_valid = 1'b1; req_addr = 10'd0;
    tick();
    req_valid = 1'b0;
    chk_rsp("t3_refetch", 1, 16'h1111, 10'd0, 0);
    tick();

    // 4: range boundaries with DEPTH=1000
    req_valid = 1'b1; req_addr = 10'd999;
    tick();
    chk_rsp("t4_last_in_range", 1, 16'h9999, 10'd999, 0);
    req_addr = 10'd1000;
    tick();
    chk_rsp("t4_first_oor", 1, 16'h0, 10'd1000, 1);
    req_addr = 10'd1023;
    tick();
    chk_rsp("t4_oor_1023", 1, 16'h0, 10'd1023, 1);
    req_valid = 1'b0;
    tick();

    // 5: reset with two buffered responses
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 10'd0;
    tick();
    req_addr = 10'd1;
    tick();
    req_valid = 1'b0;
    chk("t5_buffered", 32'(rsp_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_rsp("t5_after_reset", 0, 16'h0, 10'd0, 0);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 10'd0;
    tick();
    req_valid = 1'b0;
    chk_rsp("t5_ram_kept", 1, 16'h1111, 10'd0, 0);
    tick();

    // 6: corrupt one stored bit of RAM[2]
    word = '0;
    word[$bits(dut.r_mem[2])-1:0] = dut.r_mem[2];
    word[0] = ~word[0];
    dut.r_mem[2] = word[$bits(dut.r_mem[2])-1:0];
    req_valid = 1'b1; req_addr = 10'd2;
    tick();
    req_valid = 1'b0;
`ifdef IMEM_PARITY_EN
    chk_rsp("t6_parity", 1, 16'h3332, 10'd2, 1);
`else
    chk_rsp("t6_noparity", 1, 16'h3332, 10'd2, 0);
`endif
    tick();
    chk("t6_drained", 32'(rsp_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
